alu_scheduler: RTL

Controller that shares one `ALU` instance between two requesters (0 = execute stage, 1 = address/auxiliary unit) using round-robin arbitration with valid/ready handshakes. It also sequences multi-cycle shifts. The ALU shifts by only one power of two per pass, so an arbitrary 5-bit shift amount is decomposed into successive ALU passes with the intermediate result fed back. It sits between the requesters and the combinational `ALU`, which is instantiated beside it and driven through the `alu_*` ports.

---
 rtl/alu_defs.sv | 24 ++
 rtl/alu_rr_arb.sv | 15 +
 rtl/alu_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared ALU opcode encodings, shift classification and scheduler state encoding.
package alu_defs;

    localparam logic [3:0] ALU_ADD          = 4'h0;
    localparam logic [3:0] ALU_SUB          = 4'h1;
    localparam logic [3:0] ALU_AND          = 4'h2;
    localparam logic [3:0] ALU_OR           = 4'h3;
    localparam logic [3:0] ALU_XOR          = 4'h4;
    localparam logic [3:0] ALU_SLT          = 4'h5;
    localparam logic [3:0] ALU_SHIFTL       = 4'h6;
    localparam logic [3:0] ALU_SHIFTR       = 4'h7;
    localparam logic [3:0] ALU_SHIFTR_ARITH = 4'h8;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_EXEC,
        SCHED_RESP
    } sched_state_e;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SHIFTL) || (op == ALU_SHIFTR) || (op == ALU_SHIFTR_ARITH);
    endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter: on a tie, the requester not granted last wins.
module alu_rr_arb (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between two requesters and decomposes shifts into
// power-of-two passes with the intermediate result fed back.
module alu_scheduler
    import alu_defs::*;
#(
    parameter int unsigned W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0][3:0]    req_op,
    input  logic [1:0][W-1:0]  req_a,
    input  logic [1:0][W-1:0]  req_b,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [W-1:0]       rsp_result,
    output logic               rsp_zero,
    output logic [W-1:0]       alu_inp1,
    output logic [W-1:0]       alu_inp2,
    output logic [3:0]         alu_control,
    input  logic [W-1:0]       alu_result,
    input  logic               alu_zero
);

    sched_state_e state_q;
    logic         owner_q;
    logic         last_q;
    logic [3:0]   op_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] b_q;
    logic [4:0]   amt_q;
    logic         sign_q;

    logic [1:0]   grant;
    logic         sel;
    logic [4:0]   amt_low;
    logic [4:0]   amt_next;
    logic         shift_op;

    alu_rr_arb u_arb (
        .valid (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    assign req_ready = (state_q == SCHED_IDLE) ? grant : 2'b00;
    assign sel       = grant[1];
    assign amt_low   = amt_q & (~amt_q + 5'd1);
    assign amt_next  = amt_q & ~amt_low;
    assign shift_op  = is_shift(op_q);

    always_comb begin
        alu_inp1    = '0;
        alu_inp2    = '0;
        alu_control = ALU_ADD;
        if (state_q == SCHED_EXEC) begin
            alu_inp1    = acc_q;
            alu_control = op_q;
            if (shift_op) begin
                alu_inp2 = {{(W-5){1'b0}}, amt_low};
                // The ALU always fills with ones; a positive operand needs a logical shift.
                if (op_q == ALU_SHIFTR_ARITH && !sign_q) begin
                    alu_control = ALU_SHIFTR;
                end
            end else begin
                alu_inp2 = b_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SCHED_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            op_q       <= ALU_ADD;
            acc_q      <= '0;
            b_q        <= '0;
            amt_q      <= '0;
            sign_q     <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            unique case (state_q)
                SCHED_IDLE: begin
                    if (|(req_valid & req_ready)) begin
                        owner_q <= sel;
                        op_q    <= req_op[sel];
                        acc_q   <= req_a[sel];
                        b_q     <= req_b[sel];
                        amt_q   <= req_b[sel][4:0];
                        sign_q  <= req_a[sel][W-1];
                        state_q <= SCHED_EXEC;
                    end
                end
                SCHED_EXEC: begin
                    if (shift_op && amt_next != 5'd0) begin
                        acc_q <= alu_result;
                        amt_q <= amt_next;
                    end else begin
                        amt_q      <= 5'd0;
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_valid  <= {owner_q, ~owner_q};
                        state_q    <= SCHED_RESP;
                    end
                end
                SCHED_RESP: begin
                    if (rsp_ready[owner_q]) begin
                        last_q    <= owner_q;
                        rsp_valid <= 2'b00;
                        state_q   <= SCHED_IDLE;
                    end
                end
                default: state_q <= SCHED_IDLE;
            endcase
        end
    end

endmodule
